// File: rtl/parking_gate_scheduler_pkg.sv
// Shared types for the car-park gate: FSM state encoding, requester side, display codes.
package parking_gate_scheduler_pkg;

    localparam int unsigned SEG_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_AUTH     = 3'd1,
        ST_OPEN_IN  = 3'd2,
        ST_OPEN_OUT = 3'd3,
        ST_GAP      = 3'd4
    } gate_state_t;

    typedef enum logic {
        SIDE_ENTRY = 1'b0,
        SIDE_EXIT  = 1'b1
    } side_t;

    // Active-high seven-segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [SEG_W-1:0] hex_seg(input logic [3:0] digit);
        logic [SEG_W-1:0] seg;
        case (digit)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/parking_occupancy_counter.sv
// Saturating lot occupancy counter with registered full/empty flags.
module parking_occupancy_counter #(
    parameter int unsigned CAPACITY = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic [CNT_W-1:0] count_next;

    // Next count, clamped to [0, CAPACITY]; simultaneous strobes cancel.
    always_comb begin
        count_next = count;
        if (inc && !dec && (count < CAP)) begin
            count_next = count + CNT_W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Count and flags update together so full/empty never lag the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_next;
            full  <= (count_next == CAP);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Shared barrier sequencer: round-robin entry/exit arbitration, entry authorisation, occupancy.
module parking_gate_scheduler
    import parking_gate_scheduler_pkg::*;
#(
    parameter int unsigned CAPACITY     = 8,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned AUTH_TIMEOUT = 16,
    parameter int unsigned OPEN_CYCLES  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             auth_ok,
    input  logic             auth_fail,
    output logic             auth_start,
    output logic             gate_open,
    output logic             dir_in,
    output logic             deny,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);

    localparam int unsigned TMR_MAX = (AUTH_TIMEOUT > OPEN_CYCLES) ? AUTH_TIMEOUT : OPEN_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] AUTH_LAST = TMR_W'(AUTH_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);

    gate_state_t      state;
    gate_state_t      state_next;
    side_t            last_served;
    side_t            last_next;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_next;
    logic             auth_start_next;
    logic             gate_open_next;
    logic             dir_in_next;
    logic             deny_next;
    logic             occ_inc;
    logic             occ_dec;
    logic             entry_ok;
    logic             exit_ok;

    assign entry_ok = entry_req & ~full;
    assign exit_ok  = exit_req & ~empty;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, timer, arbitration and next values of the registered outputs.
    always_comb begin
        state_next      = state;
        last_next       = last_served;
        timer_next      = '0;
        auth_start_next = 1'b0;
        deny_next       = 1'b0;
        occ_inc         = 1'b0;
        occ_dec         = 1'b0;

        case (state)
            ST_IDLE: begin
                // Entry wins only if it is alone or exit was served last.
                if (entry_ok && (!exit_ok || (last_served == SIDE_EXIT))) begin
                    state_next      = ST_AUTH;
                    auth_start_next = 1'b1;
                    last_next       = SIDE_ENTRY;
                end else if (exit_ok) begin
                    state_next = ST_OPEN_OUT;
                    last_next  = SIDE_EXIT;
                end
            end
            ST_AUTH: begin
                if (auth_ok) begin
                    state_next = ST_OPEN_IN;
                end else if (auth_fail || (timer == AUTH_LAST)) begin
                    state_next = ST_GAP;
                    deny_next  = 1'b1;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            ST_OPEN_IN: begin
                if (timer == OPEN_LAST) begin
                    state_next = ST_GAP;
                    occ_inc    = 1'b1;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            ST_OPEN_OUT: begin
                if (timer == OPEN_LAST) begin
                    state_next = ST_GAP;
                    occ_dec    = 1'b1;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        gate_open_next = (state_next == ST_OPEN_IN) || (state_next == ST_OPEN_OUT);
        dir_in_next    = (state_next == ST_OPEN_IN);
    end

    // Timer, round-robin pointer and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer       <= '0;
            last_served <= SIDE_ENTRY;
            auth_start  <= 1'b0;
            gate_open   <= 1'b0;
            dir_in      <= 1'b0;
            deny        <= 1'b0;
        end else begin
            timer       <= timer_next;
            last_served <= last_next;
            auth_start  <= auth_start_next;
            gate_open   <= gate_open_next;
            dir_in      <= dir_in_next;
            deny        <= deny_next;
        end
    end

    // Lot occupancy, bumped on the last open cycle of each passage.
    parking_occupancy_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occupancy (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (occ_inc),
        .dec     (occ_dec),
        .count   (occupancy),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Scoreboard bench for parking_gate_scheduler: expected passages/denies queued at stimulus time.
module tb_parking_gate_scheduler;

    localparam int unsigned CAPACITY     = 8;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned AUTH_TIMEOUT = 16;
    localparam int unsigned OPEN_CYCLES  = 8;

    localparam int K_IN   = 0;
    localparam int K_OUT  = 1;
    localparam int K_DENY = 2;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             entry_req = 1'b0;
    logic             exit_req  = 1'b0;
    logic             auth_ok   = 1'b0;
    logic             auth_fail = 1'b0;
    logic             auth_start;
    logic             gate_open;
    logic             dir_in;
    logic             deny;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;

    parking_gate_scheduler #(
        .CAPACITY     (CAPACITY),
        .CNT_W        (CNT_W),
        .AUTH_TIMEOUT (AUTH_TIMEOUT),
        .OPEN_CYCLES  (OPEN_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .auth_ok    (auth_ok),
        .auth_fail  (auth_fail),
        .auth_start (auth_start),
        .gate_open  (gate_open),
        .dir_in     (dir_in),
        .deny       (deny),
        .occupancy  (occupancy),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int occ;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   exp_occ = 0;
    bit   mon_en  = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic pop_check(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_unexpected_event", 32'(kind), 32'hFFFF);
        end else begin
            e = sb.pop_front();
            check_eq("sb_kind", 32'(kind), 32'(e.kind));
            check_eq("sb_occ", 32'(occupancy), 32'(e.occ));
        end
    endtask

    // Monitor: reconstructs each passage and deny pulse, then checks it against the queue.
    bit in_pass  = 1'b0;
    bit pass_dir = 1'b0;
    int pass_len = 0;
    always @(negedge clk) begin
        if (!reset_n || !mon_en) begin
            in_pass  = 1'b0;
            pass_len = 0;
        end else begin
            if (gate_open === 1'b1) begin
                if (!in_pass) begin
                    in_pass  = 1'b1;
                    pass_dir = dir_in;
                    pass_len = 0;
                end
                pass_len++;
            end else if (in_pass) begin
                in_pass = 1'b0;
                check_eq("pass_len", 32'(pass_len), 32'(OPEN_CYCLES));
                pop_check(pass_dir ? K_IN : K_OUT);
            end
            if (deny === 1'b1) begin
                pop_check(K_DENY);
            end
        end
    end

    // Wait for the queue to drain with the gate closed, then one more cycle so the FSM is in IDLE.
    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && gate_open == 1'b0) done = 1'b1;
        end
        if (!done) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_auth_start(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (auth_start === 1'b1) seen = 1'b1;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic do_exit();
        exp_occ--;
        sb.push_back('{K_OUT, exp_occ});
        exit_req = 1'b1;
        @(negedge clk);
        check_eq("exit_gate_latency", 32'(gate_open), 32'd1);
        check_eq("exit_dir", 32'(dir_in), 32'd0);
        exit_req = 1'b0;
        wait_idle();
    endtask

    task automatic do_entry(input int dly, input bit both);
        exp_occ++;
        sb.push_back('{K_IN, exp_occ});
        entry_req = 1'b1;
        wait_auth_start("entry_auth_start");
        entry_req = 1'b0;
        repeat (dly) @(negedge clk);
        auth_ok   = 1'b1;
        auth_fail = both;
        @(negedge clk);
        auth_ok   = 1'b0;
        auth_fail = 1'b0;
        check_eq("entry_gate_latency", 32'(gate_open), 32'd1);
        check_eq("entry_dir", 32'(dir_in), 32'd1);
        wait_idle();
    endtask

    initial begin
        bit any;
        bit seen;
        int cnt;
        int falls;
        int low_run;
        bit prev_g;

        // Reset values.
        repeat (3) @(negedge clk);
        check_eq("rst_occ", 32'(occupancy), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_gate", 32'(gate_open), 32'd0);
        check_eq("rst_auth_start", 32'(auth_start), 32'd0);
        check_eq("rst_deny", 32'(deny), 32'd0);
        check_eq("rst_dir", 32'(dir_in), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Exit request on an empty lot is never granted.
        any = 1'b0;
        exit_req = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (gate_open || auth_start || deny) any = 1'b1;
        end
        exit_req = 1'b0;
        check_eq("empty_exit_ignored", 32'(any), 32'd0);
        @(negedge clk);

        // Entry authorised three cycles after auth_start.
        do_entry(3, 1'b0);
        check_eq("after_entry_empty", 32'(empty), 32'd0);

        // Held entry with no answer times out after 16 AUTH cycles, then re-arbitrates.
        sb.push_back('{K_DENY, exp_occ});
        entry_req = 1'b1;
        wait_auth_start("timeout_auth_start");
        seen = 1'b0;
        cnt  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cnt++;
            if (deny === 1'b1) seen = 1'b1;
        end
        check_eq("timeout_cycles", 32'(cnt), 32'(AUTH_TIMEOUT));
        wait_auth_start("rearb_auth_start");
        sb.push_back('{K_DENY, exp_occ});
        entry_req = 1'b0;
        auth_fail = 1'b1;
        @(negedge clk);
        auth_fail = 1'b0;
        wait_idle();
        check_eq("deny_occ_kept", 32'(occupancy), 32'd1);

        // Bring occupancy to 3, then hold both requests: grants alternate starting with exit.
        do_entry(0, 1'b0);
        do_entry(0, 1'b0);
        sb.push_back('{K_OUT, 2});
        sb.push_back('{K_IN, 3});
        sb.push_back('{K_OUT, 2});
        sb.push_back('{K_IN, 3});
        entry_req = 1'b1;
        exit_req  = 1'b1;
        falls   = 0;
        low_run = 0;
        prev_g  = 1'b0;
        for (int i = 0; i < 400 && falls < 4; i++) begin
            @(negedge clk);
            auth_ok = auth_start;
            if (gate_open && !prev_g && falls > 0) begin
                check_eq("gap_closed_cycle", 32'(low_run >= 1), 32'd1);
            end
            if (!gate_open) low_run++;
            else low_run = 0;
            if (prev_g && !gate_open) falls++;
            prev_g = gate_open;
        end
        entry_req = 1'b0;
        exit_req  = 1'b0;
        auth_ok   = 1'b0;
        check_eq("alt_passages", 32'(falls), 32'd4);
        exp_occ = 3;
        wait_idle();

        // Fill to capacity.
        repeat (5) do_entry(1, 1'b0);
        check_eq("fill_occ", 32'(occupancy), 32'(CAPACITY));
        check_eq("fill_full", 32'(full), 32'd1);

        // Full lot ignores entry.
        any = 1'b0;
        entry_req = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (gate_open || auth_start) any = 1'b1;
        end
        check_eq("full_entry_ignored", 32'(any), 32'd0);

        // One exit frees a slot, then the waiting entry is served.
        sb.push_back('{K_OUT, 7});
        sb.push_back('{K_IN, 8});
        exit_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (gate_open === 1'b1) seen = 1'b1;
        end
        check_eq("full_exit_granted", 32'(seen), 32'd1);
        exit_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (gate_open === 1'b0) seen = 1'b1;
        end
        check_eq("after_exit_occ", 32'(occupancy), 32'd7);
        check_eq("after_exit_full", 32'(full), 32'd0);
        wait_auth_start("entry_after_full");
        entry_req = 1'b0;
        auth_ok = 1'b1;
        @(negedge clk);
        auth_ok = 1'b0;
        exp_occ = 8;
        wait_idle();
        check_eq("refill_full", 32'(full), 32'd1);

        // auth_ok and auth_fail together: ok wins, no deny.
        do_exit();
        do_entry(2, 1'b1);
        check_eq("both_pulse_occ", 32'(occupancy), 32'd8);

        // Reset during the fourth OPEN_IN cycle.
        do_exit();
        mon_en = 1'b0;
        entry_req = 1'b1;
        wait_auth_start("reset_case_auth_start");
        entry_req = 1'b0;
        auth_ok = 1'b1;
        @(negedge clk);
        auth_ok = 1'b0;
        check_eq("reset_case_open", 32'(gate_open), 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_gate", 32'(gate_open), 32'd0);
        check_eq("midrst_occ", 32'(occupancy), 32'd0);
        check_eq("midrst_empty", 32'(empty), 32'd1);
        check_eq("midrst_dir", 32'(dir_in), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
        exp_occ = 0;
        mon_en  = 1'b1;
        @(negedge clk);

        // Normal service after the mid-passage reset.
        do_entry(0, 1'b0);
        check_eq("post_rst_occ", 32'(occupancy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
